// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and
// microsecond-to-cycle helpers used to size the timing counter.
package ps2_host_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_FIRST,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_LINE_IDLE,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_RATE   = 8'hF3;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser with edge detect for one PS/2 pin; the idle-high
// reset value keeps the bus from producing a spurious edge out of reset.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign level_o = sync2_q;
    assign fall_o  = ~sync1_q & sync2_q;
    assign rise_o  = sync1_q & ~sync2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit/request handshake, LSB-first
// data with odd parity on device clock falls, ACK check and edge timeouts.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned REQ_US     = 20,
    parameter int unsigned FIRST_US   = 15000,
    parameter int unsigned EDGE_US    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    inout  wire        ps2clk,
    inout  wire        ps2data
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned REQ_CYC     = us_to_cycles(CLK_HZ, REQ_US);
    localparam int unsigned FIRST_CYC   = us_to_cycles(CLK_HZ, FIRST_US);
    localparam int unsigned EDGE_CYC    = us_to_cycles(CLK_HZ, EDGE_US);
    localparam int unsigned MAX_CYC     = max_u(max_u(INHIBIT_CYC, REQ_CYC),
                                                max_u(FIRST_CYC, EDGE_CYC));
    localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_CYC - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST    = CNT_W'(EDGE_CYC - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

    logic clk_level, clk_fall, clk_rise;
    logic data_level, data_fall, data_rise;
    logic unused_edges;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2clk),
        .level_o (clk_level),
        .fall_o  (clk_fall),
        .rise_o  (clk_rise)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2data),
        .level_o (data_level),
        .fall_o  (data_fall),
        .rise_o  (data_rise)
    );

    assign unused_edges = &{1'b0, clk_rise, data_fall, data_rise};

    // Open-drain pins: only ever pulled low, otherwise released.
    assign ps2clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2data = data_oe_q ? 1'b0 : 1'bz;

    assign tx_ready   = (state_q == ST_IDLE);
    assign tx_done    = (state_q == ST_DONE);
    assign tx_ack_err = ack_err_q;
    assign tx_timeout = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_start) begin
                    shift_d   = tx_data;
                    parity_d  = ~^tx_data;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = ST_WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_FIRST: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = ST_DATA;
                end else if (cnt_q == FIRST_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A fall in the same cycle as expiry is serviced, not timed out.
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (state_q == ST_DATA) begin
                        if (bit_cnt_q == 4'd8) begin
                            data_oe_d = ~parity_q;
                            state_d   = ST_PARITY;
                        end else begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b0, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (state_q == ST_PARITY) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_STOP;
                    end else begin
                        ack_err_d = data_level;
                        state_d   = ST_LINE_IDLE;
                    end
                end else if (cnt_q == EDGE_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LINE_IDLE: begin
                if (clk_level && data_level) begin
                    state_d = ST_DONE;
                end else if (cnt_q == EDGE_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

endmodule
